// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and port-ID helpers for the memory arbiter.
//   MEM_ADDR_W / MEM_DATA_W / MEM_MAX_OUTST : default arbiter geometry
//   port_id_t                               : widest port ID the arbiter carries
//   port_id_w()                             : bits needed to name one of n ports
package mem_arb_pkg;

    localparam int MEM_ADDR_W    = 32;
    localparam int MEM_DATA_W    = 128;
    localparam int MEM_MAX_OUTST = 4;

    // Upper bound on port count; concrete instances use port_id_w() bits.
    typedef logic [7:0] port_id_t;

    // At least one bit, so a single-bit ID field is always legal.
    function automatic int port_id_w(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo: in-order FIFO of port IDs for granted-but-unanswered
// memory transactions.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_id   : enqueue an ID (taken when not full, or when popping)
//   pop             : dequeue the head (ignored when empty)
//   full, empty     : occupancy flags
//   head            : ID at the head of the queue
module mem_arb_id_fifo #(
    parameter int  DEPTH = 4,
    parameter int  ID_W  = 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);

    logic [ID_W-1:0]  ids [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = ids[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) ids[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: N-port arbiter in front of a single line-wide memory port.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed priority
// (lowest-index requester wins, no rotation pointer).
//   clk, rst                      : clock, asynchronous active-high reset
//   port_req_i/we_i/addr_i/
//   wdata_i/wstrb_i               : per-port request fields, packed by port index
//   port_gnt_o                    : one-hot grant to the accepted port
//   port_rvalid_o, port_rdata_o   : one-hot response valid, broadcast data
//   mem_req_o ... mem_wstrb_o     : request toward memory (mirrors the winner)
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                   : memory grant and in-order responses
//   err_o                         : sticky, set by a response with nothing outstanding
//
// Handshake: a request is accepted in the cycle mem_req_o && mem_gnt_i; the
// winning port sees port_gnt_o in that same cycle and must hold its fields
// stable until then. Memory answers every accepted request with exactly one
// mem_rvalid_i, in order; there is no back-pressure on responses.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int  N_PORTS   = 2,
    parameter int  ADDR_W    = MEM_ADDR_W,
    parameter int  DATA_W    = MEM_DATA_W,
    parameter int  MAX_OUTST = MEM_MAX_OUTST,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORTS-1:0]    port_req_i,
    input  logic [N_PORTS-1:0]    port_we_i,
    input  logic [N_PORTS*ADDR_W-1:0] port_addr_i,
    input  logic [N_PORTS*DATA_W-1:0] port_wdata_i,
    input  logic [N_PORTS*STRB_W-1:0] port_wstrb_i,
    output logic [N_PORTS-1:0]    port_gnt_o,
    output logic [N_PORTS-1:0]    port_rvalid_o,
    output logic [DATA_W-1:0]     port_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [STRB_W-1:0]     mem_wstrb_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  err_o
);

    localparam int ID_W = port_id_w(N_PORTS);

    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head_id;
    logic [ID_W-1:0] start;
    logic [ID_W-1:0] win;
    logic            accept;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [ID_W-1:0] rr_ptr;
    assign start = rr_ptr;
`endif

    // Scan from the highest offset down so the nearest requester at or
    // after start overwrites the others and wins.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (port_req_i[idx]) win = ID_W'(idx);
        end
    end

    assign mem_req_o   = (|port_req_i) && !fifo_full;
    assign accept      = mem_req_o && mem_gnt_i;
    assign mem_we_o    = mem_req_o ? port_we_i[win] : 1'b0;
    assign mem_addr_o  = mem_req_o ? port_addr_i[win*ADDR_W +: ADDR_W]  : '0;
    assign mem_wdata_o = mem_req_o ? port_wdata_i[win*DATA_W +: DATA_W] : '0;
    assign mem_wstrb_o = mem_req_o ? port_wstrb_i[win*STRB_W +: STRB_W] : '0;

    always_comb begin
        port_gnt_o    = '0;
        port_rvalid_o = '0;
        if (accept && !rst)                port_gnt_o[win]        = 1'b1;
        if (mem_rvalid_i && !fifo_empty)   port_rvalid_o[head_id] = 1'b1;
    end

    assign port_rdata_o = mem_rdata_i;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .ID_W  (ID_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (win),
        .pop     (mem_rvalid_i),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(win) == N_PORTS - 1) ? '0 : win + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised N-port memory arbiter between the cache channels (instruction, data, and later prefetch) and the single line-wide main-memory port.
- Arbitrates requests onto the memory req/gnt handshake, round-robin by default.
- Tracks up to MAX_OUTST granted-but-unanswered transactions in an in-order ID FIFO.
- Routes each memory rvalid back to the port that issued the request.
- Instantiated between the cache tops and the memory model, replacing direct one-cache-to-one-memory wiring.

## Interface
Parameters:
- N_PORTS, 2, number of requester ports (port 0 = instruction, port 1 = data); minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 128, line data width; STRB_W = DATA_W/8.
- MAX_OUTST, 4, maximum outstanding transactions; minimum 1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- port_req_i  in  N_PORTS  per-port request.
- port_we_i  in  N_PORTS  per-port write enable.
- port_addr_i  in  N_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W].
- port_wdata_i  in  N_PORTS*DATA_W  per-port write data.
- port_wstrb_i  in  N_PORTS*STRB_W  per-port byte strobes.
- port_gnt_o  out  N_PORTS  one-hot grant.
- port_rvalid_o  out  N_PORTS  one-hot response valid.
- port_rdata_o  out  DATA_W  response data, broadcast to all ports.
- mem_req_o, mem_we_o  out  1  downstream request and write enable.
- mem_addr_o  out  ADDR_W  downstream address.
- mem_wdata_o  out  DATA_W  downstream write data.
- mem_wstrb_o  out  STRB_W  downstream byte strobes.
- mem_gnt_i, mem_rvalid_i  in  1  downstream grant and response valid.
- mem_rdata_i  in  DATA_W  downstream response data.
- err_o  out  1  sticky protocol error.

## Operation
- Handshake: a transaction is accepted when mem_req_o && mem_gnt_i. A requester holds req/we/addr/wdata/wstrb stable until its port_gnt_o is seen.
- Memory returns exactly one rvalid per accepted transaction, reads and writes alike, in order. rdata is meaningful for reads only.
- Selection (combinational): the winner is the first requesting port at or after rr_ptr, scanning upward with wrap-around modulo N_PORTS.
- mem_req_o = |port_req_i && !fifo_full. When the FIFO is full, no port can win and mem_req_o = 0.
- The mem_* request fields mirror the winning port. When there is no request they drive 0.
- port_gnt_o[w] = mem_gnt_i && mem_req_o, where w is the winner; all other grant bits are 0.
- On acceptance:
  - push w into the ID FIFO;
  - rr_ptr <= (w+1) mod N_PORTS.
- Response: port_rvalid_o[head] = mem_rvalid_i && !fifo_empty, where head is the ID at the FIFO head. port_rdata_o = mem_rdata_i. The FIFO pops on the same rvalid.
- Simultaneous acceptance and rvalid: push and pop in the same cycle, so occupancy is unchanged. This is legal even when the FIFO is full, because the pop frees a slot. With the FIFO full, mem_req_o is still 0 in that cycle; the freed slot is used from the next cycle.
- mem_rvalid_i while the FIFO is empty: no port_rvalid_o, and err_o sets. err_o holds until reset.
- Reset (asynchronous, also mid-transaction):
  - FIFO emptied, rr_ptr = 0, err_o = 0.
  - In-flight transactions are discarded. Memory is reset on the same signal.

## Timing
- Request path and response path are both combinational, adding zero cycles. Memory latency is passed through unchanged.
- Back-to-back grants every cycle are supported until MAX_OUTST transactions are outstanding.
- Occupancy counter is $clog2(MAX_OUTST+1) bits wide. FIFO pointers are $clog2(MAX_OUTST) bits and wrap at MAX_OUTST. This holds for non-power-of-two MAX_OUTST as well.
- Output values during reset:
  - all port_gnt_o = 0 and all port_rvalid_o = 0;
  - err_o = 0;
  - mem_req_o follows the request inputs and is gated off only by fifo_full, which is 0 in reset.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest-index requesting port always wins. rr_ptr is removed.
- Undefined (default): round-robin as described under Operation.
- FIFO, routing and error behaviour are identical in both modes.

## Structure
- Package mem_arb_pkg holds:
  - default constants MEM_ADDR_W = 32, MEM_DATA_W = 128, MEM_MAX_OUTST = 4;
  - the port-ID typedef helper.
- Sub-module mem_arb_id_fifo: synchronous FIFO of port IDs with push, pop, full, empty and head outputs, parametrised by depth and ID width. It is the only stateful sub-block besides rr_ptr and err_o.

## Test plan
- Single port: port 0 reads 0x40 with memory latency 3 → port_gnt_o = 01 in the accept cycle; 3 cycles later port_rvalid_o = 01 with rdata = memory line.
- Contention, round-robin: both ports requesting continuously with mem_gnt_i = 1 and immediate rvalid → grants alternate 01,10,01,10. With MEM_ARB_FIXED_PRIO_EN defined → grants are 01 every cycle.
- Outstanding limit: MAX_OUTST = 4, rvalid withheld → exactly 4 grants, then mem_req_o = 0. One rvalid → the next request is granted the following cycle.
- Ordering: grants to ports 1,0,1, then 3 rvalids → port_rvalid_o = 10, 01, 10 in order. A push and pop in the same cycle keep occupancy constant.
- Error and reset: mem_rvalid_i with the FIFO empty → err_o = 1 and no port_rvalid_o. Asserting rst with 2 transactions outstanding → FIFO empty, err_o = 0, rr_ptr = 0 immediately (asynchronously).
